// File: rtl/bcd_mod11_serial_if.sv
// Operand/result handshake bundle for bcd_mod11_serial.
// master drives operands and consumes results; slave is the reducer.
interface bcd_mod11_serial_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic [4*NUM_DIGITS-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [3:0]              remainder;
   logic                    divisible;
   logic                    err;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, remainder, divisible, err
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, remainder, divisible, err
   );
endinterface

// File: rtl/bcd_mod11_serial.sv
// Serial BCD mod-11 reducer, MSD first; invalid-digit flag when BCD_CHECK_EN is defined.
// Latency: result valid NUM_DIGITS edges after the accepting edge.
// Backpressure: result held in DONE until out_ready; no new operand accepted until then.
module bcd_mod11_serial #(
   parameter int NUM_DIGITS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   bcd_mod11_serial_if.slave bus
);
   localparam int W  = 4 * NUM_DIGITS;
   localparam int CW = $clog2(NUM_DIGITS + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [W-1:0]  shreg;
   logic [3:0]    acc;
   logic [CW-1:0] cnt;

   logic [3:0] dig;
   logic [3:0] dig_red;
   logic [4:0] diff;
   logic [3:0] acc_nxt;
   logic       err_flag;

   // 10 == -1 (mod 11), so Horner's step r*10 + d becomes d - r.
   always_comb begin
      dig     = shreg[W-1 -: 4];
      dig_red = (dig > 4'd10) ? (dig - 4'd11) : dig;
      diff    = {1'b0, dig_red} - {1'b0, acc};
      acc_nxt = diff[4] ? (diff[3:0] + 4'd11) : diff[3:0];
   end

`ifdef BCD_CHECK_EN
   logic bad_digit;
   logic err_q;

   always_comb begin
      bad_digit = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bus.in_data[4*k +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (state == IDLE && bus.in_valid) begin
         err_q <= bad_digit;
      end
   end

   assign err_flag = err_q;
`else
   assign err_flag = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         shreg <= '0;
         acc   <= 4'd0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  shreg <= bus.in_data;
                  acc   <= 4'd0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= acc_nxt;
               shreg <= shreg << 4;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) state <= DONE;
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result fields are forced to zero outside DONE so stale values never leak.
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.remainder = bus.out_valid ? acc : 4'd0;
   assign bus.err       = bus.out_valid & err_flag;
   assign bus.divisible = bus.out_valid & (acc == 4'd0) & ~err_flag;
endmodule

// File: tb/tb_bcd_mod11_serial.sv
// Self-checking bench for bcd_mod11_serial at NUM_DIGITS = 4, 1 and 16.
module tb_bcd_mod11_serial;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  in_vld;
   logic [63:0] in_dat;
   logic        out_ready;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   bcd_mod11_serial_if #(.NUM_DIGITS(4))  if4 ();
   bcd_mod11_serial_if #(.NUM_DIGITS(1))  if1 ();
   bcd_mod11_serial_if #(.NUM_DIGITS(16)) if16 ();

   assign if4.in_valid   = in_vld[0];
   assign if1.in_valid   = in_vld[1];
   assign if16.in_valid  = in_vld[2];
   assign if4.in_data    = in_dat[15:0];
   assign if1.in_data    = in_dat[3:0];
   assign if16.in_data   = in_dat;
   assign if4.out_ready  = out_ready;
   assign if1.out_ready  = out_ready;
   assign if16.out_ready = out_ready;

   bcd_mod11_serial #(.NUM_DIGITS(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
   bcd_mod11_serial #(.NUM_DIGITS(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
   bcd_mod11_serial #(.NUM_DIGITS(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

   typedef struct packed {
      logic       ir;
      logic       ov;
      logic [3:0] rem;
      logic       div;
      logic       err;
   } obs_t;

   typedef struct {
      logic [15:0] op;
      logic [3:0]  rem;
      logic        div;
   } vec_t;

   function automatic obs_t observe(input int sel);
      obs_t o;
      case (sel)
         0:       o = '{if4.in_ready, if4.out_valid, if4.remainder, if4.divisible, if4.err};
         1:       o = '{if1.in_ready, if1.out_valid, if1.remainder, if1.divisible, if1.err};
         default: o = '{if16.in_ready, if16.out_valid, if16.remainder, if16.divisible, if16.err};
      endcase
      return o;
   endfunction

   function automatic int ndig(input int sel);
      return (sel == 0) ? 4 : (sel == 1) ? 1 : 16;
   endfunction

   // Reference: value of the digit string (non-BCD digits reduced by 11) mod 11.
   function automatic logic [3:0] ref_rem(input logic [63:0] op, input int n);
      longint unsigned v = 0;
      longint unsigned p = 1;
      for (int k = 0; k < n; k++) begin
         int d = int'(op[4*k +: 4]);
         if (d >= 11) d = d - 11;
         v = v + longint'(d) * p;
         p = p * 10;
      end
      return 4'(v % 11);
   endfunction

   function automatic logic ref_err(input logic [63:0] op, input int n);
      logic e = 1'b0;
`ifdef BCD_CHECK_EN
      for (int k = 0; k < n; k++) if (op[4*k +: 4] > 4'd9) e = 1'b1;
`else
      if (n < 0 || op === 64'hx) e = 1'b0;
`endif
      return e;
   endfunction

   function automatic logic [63:0] rand_op(input int n);
      logic [63:0] op = '0;
      for (int k = 0; k < n; k++) begin
         op[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(0, 9));
      end
      return op;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Accept op on the selected DUT, return outputs at the first out_valid and the edge count.
   task automatic run(input int sel, input logic [63:0] op, output obs_t o, output int lat);
      int w = 0;
      out_ready = 1'b1;
      while (!observe(sel).ir && w < 100) begin
         @(posedge clk); #1; w++;
      end
      in_dat = op;
      in_vld = 3'b001 << sel;
      @(posedge clk); #1;
      in_vld = 3'b000;
      in_dat = {$urandom, $urandom};
      lat = 0;
      while (!observe(sel).ov && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      o = observe(sel);
      @(posedge clk); #1;
   endtask

   task automatic rand_check(input int sel, input int count);
      obs_t        o;
      int          lat;
      logic [63:0] op;
      logic [3:0]  er;
      logic        ee;
      for (int i = 0; i < count; i++) begin
         op = rand_op(ndig(sel));
         er = ref_rem(op, ndig(sel));
         ee = ref_err(op, ndig(sel));
         run(sel, op, o, lat);
         chk($sformatf("rand%0d_rem op=%0h", sel, op), 64'(o.rem), 64'(er));
         chk($sformatf("rand%0d_err op=%0h", sel, op), 64'(o.err), 64'(ee));
         chk($sformatf("rand%0d_div op=%0h", sel, op), 64'(o.div), 64'(er == 4'd0 && !ee));
         chk($sformatf("rand%0d_lat", sel), 64'(lat), 64'(ndig(sel)));
      end
   endtask

   initial begin
      vec_t vecs[8];
      obs_t o;
      int   lat;
      int   seen;

      vecs[0] = '{16'h1331, 4'd0,  1'b1};
      vecs[1] = '{16'h1000, 4'd10, 1'b0};
      vecs[2] = '{16'h1234, 4'd2,  1'b0};
      vecs[3] = '{16'h9999, 4'd0,  1'b1};
      vecs[4] = '{16'h0000, 4'd0,  1'b1};
      vecs[5] = '{16'h0121, 4'd0,  1'b1};
      vecs[6] = '{16'h0007, 4'd7,  1'b0};
      vecs[7] = '{16'h0010, 4'd10, 1'b0};

      rst_n     = 1'b0;
      in_vld    = 3'b000;
      in_dat    = '0;
      out_ready = 1'b1;

      #3;
      o = observe(0);
      chk("rst_in_ready", 64'(o.ir), 64'd1);
      chk("rst_out_valid", 64'(o.ov), 64'd0);
      chk("rst_remainder", 64'(o.rem), 64'd0);
      chk("rst_divisible", 64'(o.div), 64'd0);
      chk("rst_err", 64'(o.err), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run(0, {48'd0, vecs[i].op}, o, lat);
         chk($sformatf("vec_rem %h", vecs[i].op), 64'(o.rem), 64'(vecs[i].rem));
         chk($sformatf("vec_div %h", vecs[i].op), 64'(o.div), 64'(vecs[i].div));
         chk($sformatf("vec_err %h", vecs[i].op), 64'(o.err), 64'd0);
         chk($sformatf("vec_lat %h", vecs[i].op), 64'(lat), 64'd4);
      end

      run(0, 64'h1A34, o, lat);
      chk("bad_digit_rem", 64'(o.rem), 64'(ref_rem(64'h1A34, 4)));
      chk("bad_digit_err", 64'(o.err), 64'(ref_err(64'h1A34, 4)));
      chk("bad_digit_div", 64'(o.div), 64'd0);

      // Held result under backpressure; IN_VALID pulses in DONE must be ignored.
      out_ready = 1'b0;
      in_dat    = 64'h0;
      in_vld    = 3'b001;
      @(posedge clk); #1;
      in_vld = 3'b000;
      lat    = 0;
      while (!if4.out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      chk("hold_lat", 64'(lat), 64'd4);
      for (int i = 0; i < 5; i++) begin
         in_vld = 3'(i & 1);
         in_dat = 64'h1234;
         @(posedge clk); #1;
         o = observe(0);
         chk($sformatf("hold%0d_ov", i), 64'(o.ov), 64'd1);
         chk($sformatf("hold%0d_ir", i), 64'(o.ir), 64'd0);
         chk($sformatf("hold%0d_rem", i), 64'(o.rem), 64'd0);
         chk($sformatf("hold%0d_div", i), 64'(o.div), 64'd1);
      end
      in_vld    = 3'b000;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_ov", 64'(if4.out_valid), 64'd0);
      chk("release_ir", 64'(if4.in_ready), 64'd1);

      // Reset in the middle of RUN discards the operand.
      in_dat = 64'h1331;
      in_vld = 3'b001;
      @(posedge clk); #1;
      in_vld = 3'b000;
      @(posedge clk);
      @(posedge clk); #1;
      chk("pre_rst_ir", 64'(if4.in_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_ov", 64'(if4.out_valid), 64'd0);
      chk("midrun_rst_ir", 64'(if4.in_ready), 64'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (if4.out_valid) seen++;
      end
      chk("no_result_after_rst", 64'(seen), 64'd0);
      run(0, 64'h0121, o, lat);
      chk("after_rst_rem", 64'(o.rem), 64'd0);
      chk("after_rst_div", 64'(o.div), 64'd1);
      chk("after_rst_lat", 64'(lat), 64'd4);

      run(1, 64'h7, o, lat);
      chk("n1_rem", 64'(o.rem), 64'd7);
      chk("n1_lat", 64'(lat), 64'd1);

      rand_check(1, 10);
      rand_check(2, 20);
      rand_check(0, 30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bcd_mod11_serial.md
BCD_MOD11_SERIAL -- requirements
Module: bcd_mod11_serial

Interface
REQ-001 SHALL use one clock and one reset: the reset is asynchronous and active-low.
REQ-002 SHALL have parameter NUM_DIGITS, default 4: number of BCD digits per operand, legal range 1..16.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 RST_N  input  1  asynchronous active-low reset.
REQ-005 IN_VALID  input  1  operand present on INPUT.
REQ-006 IN_READY  output  1  block can accept an operand.
REQ-007 INPUT  input  4*NUM_DIGITS  packed BCD operand; digit k is INPUT[4k+3:4k], and digit NUM_DIGITS-1 is the MSD.
REQ-008 OUT_VALID  output  1  result is valid.
REQ-009 OUT_READY  input  1  consumer accepts the result.
REQ-010 REMAINDER  output  4  operand mod 11, range 0..10.
REQ-011 DIVISIBLE  output  1  1 when REMAINDER==0 and ERR==0.
REQ-012 ERR  output  1  invalid BCD digit detected (see Configuration).

Function
REQ-013 SHALL implement the states IDLE, RUN and DONE.
REQ-014 IDLE: IN_READY=1 and OUT_VALID=0.
- An IN_VALID&&IN_READY edge captures INPUT into the shift register.
- The same edge clears the accumulator r to 0 and the digit counter to 0, and moves to RUN.
REQ-015 RUN: each edge consumes one digit, MSD first, using r <= (d' - r) mod 11.
- d' = d if d<11, else d-11.
- Basis: 10 = -1 mod 11. The result SHALL stay within 0..10 with no wider intermediate than 5 bits.
REQ-016 RUN: after NUM_DIGITS consuming edges, move to DONE. OUT_VALID rises exactly NUM_DIGITS edges after the accepting edge.
REQ-017 DONE: OUT_VALID=1, with REMAINDER, DIVISIBLE and ERR held stable until an OUT_VALID&&OUT_READY edge.
REQ-018 The OUT_VALID&&OUT_READY edge in DONE moves to IDLE. IN_READY rises on that edge. There is no same-cycle accept of a new operand in DONE.
REQ-019 IN_READY SHALL be 0 in RUN and DONE. IN_VALID in those states SHALL be ignored and SHALL not corrupt state.
REQ-020 INPUT SHALL be sampled only on the accepting edge. Later changes to INPUT SHALL have no effect on the result.
REQ-021 When NUM_DIGITS=1, RUN SHALL last exactly one edge.
REQ-022 OUT_READY held high while in IDLE or RUN SHALL have no effect.
REQ-023 The digit counter width SHALL be $clog2(NUM_DIGITS+1) and SHALL not wrap within an operation.

Reset
REQ-024 When RST_N=0, the block SHALL enter IDLE immediately, regardless of the clock.
REQ-025 Reset values:
- IN_READY=1 as soon as RST_N is low; it remains 1 in IDLE after deassertion.
- OUT_VALID=0, REMAINDER=0, DIVISIBLE=0, ERR=0.
- Accumulator, counter and shift register all 0.
REQ-026 Reset asserted during RUN or DONE SHALL discard the in-flight operand, and no OUT_VALID SHALL be produced for it.
REQ-027 The first accepting edge after RST_N deasserts SHALL behave as a normal start.

Configuration
REQ-028 Macro BCD_CHECK_EN controls invalid-digit detection.
- Defined: on the accepting edge, ERR is latched as the OR over all digits of (digit>9). ERR is reported in DONE and forces DIVISIBLE=0. REMAINDER is still computed per REQ-015.
- Not defined: ERR is constant 0, there is no detection logic, and digits 10..15 are reduced per REQ-015.

Verification (NUM_DIGITS=4 unless noted)
REQ-029 INPUT=16'h1331, OUT_READY=1 -> OUT_VALID 4 edges after accept, REMAINDER=0, DIVISIBLE=1, ERR=0.
REQ-030 INPUT=16'h1000 -> REMAINDER=10, DIVISIBLE=0. Then INPUT=16'h1234 -> REMAINDER=2. Then 16'h9999 -> REMAINDER=0, DIVISIBLE=1.
REQ-031 INPUT=16'h0000, with OUT_READY low for 5 cycles after OUT_VALID:
- OUT_VALID and outputs held for those cycles, IN_READY=0 throughout, and IN_VALID pulses are ignored.
- Raising OUT_READY returns the block to IDLE on the next edge.
REQ-032 INPUT=16'h1A34:
- With BCD_CHECK_EN: ERR=1, DIVISIBLE=0.
- Without it: ERR=0, REMAINDER equals the REQ-015 reference model value.
REQ-033 Assert RST_N=0 two edges after accepting 16'h1331:
- OUT_VALID=0 immediately and IN_READY=1.
- No result is produced, and the next operand 16'h0121 gives REMAINDER=0.
REQ-034 NUM_DIGITS=1, INPUT=4'h7 -> OUT_VALID 1 edge after accept, REMAINDER=7. NUM_DIGITS=16 random sweep matches the arithmetic reference model.
